mm_fetch_arbiter: RTL and testbench
===================================

Name: mm_fetch_arbiter

Overview:
Sequences tile-by-tile fetching of matrix A and matrix B words from a single shared memory read port, and fills the A and B FIFOs that feed the load_AB processing-element chain. It arbitrates burst reads between the A and B streams using FIFO free-space credits. A prefetch runs at most one tile ahead of B, matching the double-buffered A RAM in each PE. The block sits between the memory read interface and the head of the PE chain.

Parameters:
D_WIDTH, 64, data word width
ADDR_WIDTH, 32, word address width
A_NUM_WIDTH, 4, log2 of A words per tile (A_WORDS = 2^A_NUM_WIDTH)
B_NUM_WIDTH, 4, log2 of B words per tile (B_WORDS = 2^B_NUM_WIDTH)
BURST_WIDTH, 2, log2 of burst length (BURST = 2^BURST_WIDTH); must be <= A_NUM_WIDTH and <= B_NUM_WIDTH
FIFO_DEPTH_WIDTH, 5, log2 of A/B FIFO depth
TILE_WIDTH, 8, tile counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only when busy=0
num_tiles  in  TILE_WIDTH  tile count, sampled on accepted start
base_addr_a  in  ADDR_WIDTH  A word base address, sampled on start
base_addr_b  in  ADDR_WIDTH  B word base address, sampled on start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when all tiles have been fetched
rd_req_valid  out  1  burst request valid
rd_req_ready  in  1  memory accepts the request
rd_req_addr  out  ADDR_WIDTH  burst start word address
rd_req_len  out  BURST_WIDTH+1  burst length in words, always BURST
rd_resp_valid  in  1  response word valid
rd_resp_data  in  D_WIDTH  response word
rd_resp_last  in  1  last word of the burst
a_fifo_wr_en  out  1  A FIFO write strobe
b_fifo_wr_en  out  1  B FIFO write strobe
fifo_wdata  out  D_WIDTH  write data shared by both FIFOs
a_fifo_count  in  FIFO_DEPTH_WIDTH+1  A FIFO occupancy
b_fifo_count  in  FIFO_DEPTH_WIDTH+1  B FIFO occupancy
err  out  1  sticky protocol error flag

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE; counters cleared. A reset mid-burst abandons the outstanding burst without waiting for its response.
- FSM states:
  - IDLE: on start, latch the configuration. If num_tiles=0, go to DONE. Otherwise go to ARB.
  - ARB: pick the stream to serve.
    - A is eligible if a_tile < num_tiles, a_tile <= b_tile+1, and (2^FIFO_DEPTH_WIDTH - a_fifo_count) >= BURST.
    - B is eligible if b_tile < num_tiles, b_tile < a_tile (the A tile is fully fetched), and B has the same free-space credit.
    - If both are eligible, round-robin: grant the stream not granted last; after reset, A goes first.
    - If neither is eligible, stay in ARB.
    - If both streams have finished all tiles, go to DONE.
  - REQ: hold rd_req_valid=1 with stable addr/len until rd_req_ready; then go to RESP.
    - rd_req_addr = base + tile*WORDS + beat_idx*BURST, using the granted stream's counters, computed modulo 2^ADDR_WIDTH.
  - RESP: forward each rd_resp_valid word combinationally.
    - fifo_wdata = rd_resp_data; assert the wr_en of the owning stream in the same cycle (zero added latency).
    - On the word with rd_resp_last: advance the stream's beat_idx; on beat wrap advance its tile counter; go to ARB.
  - DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- Only one burst is outstanding at a time; the owner bit is registered at grant.
- Minimum gap between bursts is 2 cycles (ARB, REQ). The FIFO occupancy inputs must reflect writes within 1 cycle.
- err is set and held until reset on any of:
  - rd_resp_valid outside RESP;
  - rd_resp_last on a word other than the BURST-th;
  - BURST words received without rd_resp_last.
  In the last two cases the burst is terminated at the BURST-th word.
- start while busy=1 is ignored.
- Tile counters are TILE_WIDTH+1 bits wide, so num_tiles = max value is handled without wrap.

Optional Feature:
MM_FETCH_PERF_EN
- Defined: adds 32-bit saturating outputs perf_stall_credit (cycles in ARB with a stream unfinished but none eligible) and perf_req_wait (cycles in REQ with rd_req_ready=0). Both clear on accepted start.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package mm_fetch_pkg holds:
  - the state enum typedef fetch_state_t (IDLE, ARB, REQ, RESP, DONE);
  - the stream_sel_t typedef (STREAM_A, STREAM_B);
  - helper function burst_addr(base, tile, beat).
- One natural sub-module, mm_stream_ctr, instantiated twice: per-stream tile/beat counters, the address generator and the credit check.

Test Plan:
- BURST=4, A_WORDS=B_WORDS=16, num_tiles=2, ready always 1, FIFOs drained → 16 bursts in total, order A0..A3 then alternating A/B. Addresses a: base_a+0,4,...,28; b: base_b+0,...,28. done exactly once. 32 writes to each FIFO.
- b_fifo_count held at 30 (depth 32) → no B bursts are issued. A stops after tile 1 (a_tile=2 would exceed b_tile+1). Releasing the count resumes B.
- rd_req_ready low for 5 cycles → rd_req_valid and rd_req_addr stay stable for the whole wait; with MM_FETCH_PERF_EN, perf_req_wait=5.
- num_tiles=0 → done pulses 2 cycles after start, with no requests issued.
- rd_resp_last on the 2nd word → err=1 and the FSM continues. Unsolicited rd_resp_valid in IDLE → err=1 and no FIFO write.
- Assert rst during RESP → all outputs 0 in the same cycle; a new start afterwards fetches from tile 0.

Source files
------------

// File: rtl/mm_fetch_pkg.sv
// Shared types and address helper for the matrix A/B fetch arbiter.
package mm_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REQ,
    RESP,
    DONE
  } fetch_state_t;

  typedef enum logic {
    STREAM_A,
    STREAM_B
  } stream_sel_t;

  // Wide intermediate; callers truncate to their address width for modulo wrap.
  function automatic logic [63:0] burst_addr(
    input logic [63:0] base,
    input logic [63:0] tile,
    input logic [63:0] beat,
    input int unsigned tile_shift,
    input int unsigned beat_shift
  );
    return base + (tile << tile_shift) + (beat << beat_shift);
  endfunction

endpackage

// File: rtl/mm_stream_ctr.sv
// Per-stream tile/beat counters, burst address generator and FIFO credit check.
module mm_stream_ctr
  import mm_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int NUM_WIDTH        = 4,
  parameter int BURST_WIDTH      = 2,
  parameter int FIFO_DEPTH_WIDTH = 5,
  parameter int TILE_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [ADDR_WIDTH-1:0]       base_in,
  input  logic [TILE_WIDTH:0]         num_tiles,
  input  logic                        advance,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_count,
  output logic [TILE_WIDTH:0]         tile,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic                        credit_ok,
  output logic                        finished
);

  localparam int BURST  = 1 << BURST_WIDTH;
  localparam int DEPTH  = 1 << FIFO_DEPTH_WIDTH;
  localparam int BEATS  = 1 << (NUM_WIDTH - BURST_WIDTH);
  localparam int BEAT_W = (NUM_WIDTH > BURST_WIDTH) ? NUM_WIDTH - BURST_WIDTH : 1;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [BEAT_W-1:0]     beat;
  logic                  beat_last;

  assign beat_last = (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      tile   <= '0;
      beat   <= '0;
    end else if (clear) begin
      base_q <= base_in;
      tile   <= '0;
      beat   <= '0;
    end else if (advance) begin
      if (beat_last) begin
        beat <= '0;
        tile <= tile + (TILE_WIDTH+1)'(1);
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  assign addr = ADDR_WIDTH'(burst_addr(64'(base_q), 64'(tile), 64'(beat),
                                       NUM_WIDTH, BURST_WIDTH));

  assign credit_ok = (fifo_count <= (FIFO_DEPTH_WIDTH+1)'(DEPTH - BURST));
  assign finished  = (tile >= num_tiles);

endmodule

// File: rtl/mm_fetch_arbiter.sv
// Tile-by-tile A/B burst fetch arbiter feeding the load_AB PE chain FIFOs.
// Optional MM_FETCH_PERF_EN adds saturating stall/wait performance counters.
module mm_fetch_arbiter
  import mm_fetch_pkg::*;
#(
  parameter int D_WIDTH          = 64,
  parameter int ADDR_WIDTH       = 32,
  parameter int A_NUM_WIDTH      = 4,
  parameter int B_NUM_WIDTH      = 4,
  parameter int BURST_WIDTH      = 2,
  parameter int FIFO_DEPTH_WIDTH = 5,
  parameter int TILE_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TILE_WIDTH-1:0]     num_tiles,
  input  logic [ADDR_WIDTH-1:0]     base_addr_a,
  input  logic [ADDR_WIDTH-1:0]     base_addr_b,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     rd_req_addr,
  output logic [BURST_WIDTH:0]      rd_req_len,
  input  logic                      rd_resp_valid,
  input  logic [D_WIDTH-1:0]        rd_resp_data,
  input  logic                      rd_resp_last,
  output logic                      a_fifo_wr_en,
  output logic                      b_fifo_wr_en,
  output logic [D_WIDTH-1:0]        fifo_wdata,
  input  logic [FIFO_DEPTH_WIDTH:0] a_fifo_count,
  input  logic [FIFO_DEPTH_WIDTH:0] b_fifo_count,
  output logic                      err
`ifdef MM_FETCH_PERF_EN
 ,output logic [31:0]               perf_stall_credit,
  output logic [31:0]               perf_req_wait
`endif
);

  localparam int BURST = 1 << BURST_WIDTH;

  fetch_state_t          state, nxt;
  stream_sel_t           owner, last_grant;
  logic [TILE_WIDTH-1:0] num_tiles_q;
  logic [TILE_WIDTH:0]   nt_ext, a_tile, b_tile;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic                  a_credit, b_credit, a_fin, b_fin;
  logic                  a_elig, b_elig, grant_a, grant_b;
  logic                  accept, resp_fire, at_last, burst_end;
  logic                  busy_q, done_q, err_q;
  logic [BURST_WIDTH:0]  wcnt;

  assign accept    = (state == IDLE) && start;
  assign nt_ext    = {1'b0, num_tiles_q};
  assign a_elig    = !a_fin && (a_tile <= b_tile + (TILE_WIDTH+1)'(1)) && a_credit;
  assign b_elig    = !b_fin && (b_tile < a_tile) && b_credit;
  assign at_last   = (wcnt == (BURST_WIDTH+1)'(BURST - 1));
  assign resp_fire = (state == RESP) && rd_resp_valid;
  assign burst_end = resp_fire && at_last;

  mm_stream_ctr #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_WIDTH       (A_NUM_WIDTH),
    .BURST_WIDTH     (BURST_WIDTH),
    .FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH),
    .TILE_WIDTH      (TILE_WIDTH)
  ) u_ctr_a (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .base_in   (base_addr_a),
    .num_tiles (nt_ext),
    .advance   (burst_end && (owner == STREAM_A)),
    .fifo_count(a_fifo_count),
    .tile      (a_tile),
    .addr      (a_addr),
    .credit_ok (a_credit),
    .finished  (a_fin)
  );

  mm_stream_ctr #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_WIDTH       (B_NUM_WIDTH),
    .BURST_WIDTH     (BURST_WIDTH),
    .FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH),
    .TILE_WIDTH      (TILE_WIDTH)
  ) u_ctr_b (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .base_in   (base_addr_b),
    .num_tiles (nt_ext),
    .advance   (burst_end && (owner == STREAM_B)),
    .fifo_count(b_fifo_count),
    .tile      (b_tile),
    .addr      (b_addr),
    .credit_ok (b_credit),
    .finished  (b_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: if (start) nxt = (num_tiles == '0) ? DONE : ARB;
      ARB: begin
        if (a_fin && b_fin) begin
          nxt = DONE;
        end else if (a_elig && (!b_elig || (last_grant == STREAM_B))) begin
          grant_a = 1'b1;
          nxt     = REQ;
        end else if (b_elig) begin
          grant_b = 1'b1;
          nxt     = REQ;
        end
      end
      REQ:     if (rd_req_ready) nxt = RESP;
      RESP:    if (burst_end) nxt = ARB;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= STREAM_A;
      last_grant  <= STREAM_B;
      num_tiles_q <= '0;
      wcnt        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (accept) begin
        num_tiles_q <= num_tiles;
        busy_q      <= 1'b1;
      end else if (state == DONE) begin
        busy_q <= 1'b0;
      end
      if (grant_a || grant_b) begin
        owner      <= grant_a ? STREAM_A : STREAM_B;
        last_grant <= grant_a ? STREAM_A : STREAM_B;
        wcnt       <= '0;
      end else if (resp_fire) begin
        wcnt <= at_last ? '0 : wcnt + (BURST_WIDTH+1)'(1);
      end
      // Early or missing last both flag here; the burst always ends on the BURST-th word.
      if ((rd_resp_valid && (state != RESP)) || (resp_fire && (rd_resp_last != at_last)))
        err_q <= 1'b1;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rd_req_valid = (state == REQ);
  assign rd_req_addr  = !rd_req_valid ? '0 : (owner == STREAM_A) ? a_addr : b_addr;
  assign rd_req_len   = rd_req_valid ? (BURST_WIDTH+1)'(BURST) : '0;
  assign a_fifo_wr_en = resp_fire && (owner == STREAM_A);
  assign b_fifo_wr_en = resp_fire && (owner == STREAM_B);
  assign fifo_wdata   = resp_fire ? rd_resp_data : '0;

`ifdef MM_FETCH_PERF_EN
  logic stall_credit;
  assign stall_credit = (state == ARB) && !(a_fin && b_fin) && !a_elig && !b_elig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_credit <= '0;
      perf_req_wait     <= '0;
    end else if (accept) begin
      perf_stall_credit <= '0;
      perf_req_wait     <= '0;
    end else begin
      if (stall_credit && (perf_stall_credit != '1))
        perf_stall_credit <= perf_stall_credit + 32'd1;
      if ((state == REQ) && !rd_req_ready && (perf_req_wait != '1))
        perf_req_wait <= perf_req_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_fetch_arbiter.sv
// Directed self-checking bench for mm_fetch_arbiter (default parameters: BURST=4, 16 words/tile, depth 32).
module tb_mm_fetch_arbiter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_tiles;
  logic [31:0] base_addr_a, base_addr_b;
  logic        busy, done;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [2:0]  rd_req_len;
  logic        rd_resp_valid, rd_resp_last;
  logic [63:0] rd_resp_data;
  logic        a_fifo_wr_en, b_fifo_wr_en;
  logic [63:0] fifo_wdata;
  logic [5:0]  a_fifo_count, b_fifo_count;
  logic        err;
`ifdef MM_FETCH_PERF_EN
  logic [31:0] perf_stall_credit, perf_req_wait;
`endif

  mm_fetch_arbiter #(
    .D_WIDTH         (64),
    .ADDR_WIDTH      (32),
    .A_NUM_WIDTH     (4),
    .B_NUM_WIDTH     (4),
    .BURST_WIDTH     (2),
    .FIFO_DEPTH_WIDTH(5),
    .TILE_WIDTH      (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_tiles        (num_tiles),
    .base_addr_a      (base_addr_a),
    .base_addr_b      (base_addr_b),
    .busy             (busy),
    .done             (done),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .rd_req_addr      (rd_req_addr),
    .rd_req_len       (rd_req_len),
    .rd_resp_valid    (rd_resp_valid),
    .rd_resp_data     (rd_resp_data),
    .rd_resp_last     (rd_resp_last),
    .a_fifo_wr_en     (a_fifo_wr_en),
    .b_fifo_wr_en     (b_fifo_wr_en),
    .fifo_wdata       (fifo_wdata),
    .a_fifo_count     (a_fifo_count),
    .b_fifo_count     (b_fifo_count),
    .err              (err)
`ifdef MM_FETCH_PERF_EN
   ,.perf_stall_credit(perf_stall_credit),
    .perf_req_wait    (perf_req_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, a_wr_cnt = 0, b_wr_cnt = 0, valid_cnt = 0;
  int s_done, s_a, s_b, s_valid;
  bit ok;
  bit order1 [16];

  always @(negedge clk) begin
    if (done)         done_cnt  <= done_cnt + 1;
    if (a_fifo_wr_en) a_wr_cnt  <= a_wr_cnt + 1;
    if (b_fifo_wr_en) b_wr_cnt  <= b_wr_cnt + 1;
    if (rd_req_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_done  = done_cnt;
    s_a     = a_wr_cnt;
    s_b     = b_wr_cnt;
    s_valid = valid_cnt;
  endtask

  task automatic start_run(input logic [7:0] nt, input logic [31:0] ba, input logic [31:0] bb);
    tick();
    num_tiles   = nt;
    base_addr_a = ba;
    base_addr_b = bb;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rd_req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_addr"}, 64'(rd_req_addr), 64'(exp_addr));
      chk({tag, "_len"}, 64'(rd_req_len), 64'd4);
    end
  endtask

  task automatic resp_burst(input string tag, input bit is_b, input logic [31:0] addr, input int last_at);
    for (int w = 0; w < 4; w++) begin
      tick();
      rd_resp_valid = 1'b1;
      rd_resp_last  = (w == last_at);
      rd_resp_data  = {(is_b ? 32'hBBBB_0000 : 32'hAAAA_0000), addr + 32'(w)};
      @(negedge clk);
      chk({tag, "_a_wr"}, 64'(a_fifo_wr_en), 64'(!is_b));
      chk({tag, "_b_wr"}, 64'(b_fifo_wr_en), 64'(is_b));
      chk({tag, "_wdata"}, fifo_wdata, {(is_b ? 32'hBBBB_0000 : 32'hAAAA_0000), addr + 32'(w)});
    end
    tick();
    rd_resp_valid = 1'b0;
    rd_resp_last  = 1'b0;
  endtask

  task automatic do_burst(input string tag, input bit is_b, input logic [31:0] addr);
    bit seen;
    wait_req(tag, addr, seen);
    if (seen) resp_burst(tag, is_b, addr, 3);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = '0; base_addr_a = '0; base_addr_b = '0;
    rd_req_ready = 1'b1; rd_resp_valid = 1'b0; rd_resp_last = 1'b0; rd_resp_data = '0;
    a_fifo_count = '0; b_fifo_count = '0;
    order1 = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(rd_req_valid), 0);
    chk("rst_addr", 64'(rd_req_addr), 0);
    chk("rst_len", 64'(rd_req_len), 0);
    chk("rst_a_wr", 64'(a_fifo_wr_en), 0);
    chk("rst_b_wr", 64'(b_fifo_wr_en), 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_err", 64'(err), 0);
    tick();
    rst = 1'b0;

    // Two tiles, free-flowing: A0..A3 first, then alternation, then B drains
    tick();
    snap();
    start_run(8'd2, 32'h0000_1000, 32'h0000_2000);
    begin
      logic [31:0] na, nb;
      na = '0;
      nb = '0;
      for (int k = 0; k < 16; k++) begin
        if (order1[k]) begin
          do_burst("t1_b", 1'b1, 32'h0000_2000 + nb * 4);
          nb++;
        end else begin
          do_burst("t1_a", 1'b0, 32'h0000_1000 + na * 4);
          na++;
        end
      end
    end
    wait_done("t1");
    repeat (3) tick();
    chk("t1_done_once", 64'(done_cnt - s_done), 1);
    chk("t1_a_writes", 64'(a_wr_cnt - s_a), 32);
    chk("t1_b_writes", 64'(b_wr_cnt - s_b), 32);
    chk("t1_busy_end", 64'(busy), 0);
    chk("t1_err", 64'(err), 0);

    // B credit starved: A fetches two tiles then stalls; address wraps modulo 2^32
    b_fifo_count = 6'd30;
    start_run(8'd2, 32'hFFFF_FFF0, 32'h0000_8000);
    for (int k = 0; k < 8; k++)
      do_burst("t2_a", 1'b0, 32'hFFFF_FFF0 + 32'(4 * k));
    tick();
    snap();
    repeat (20) @(negedge clk);
    tick();
    chk("t2_no_req_stalled", 64'(valid_cnt - s_valid), 0);
    chk("t2_busy_stalled", 64'(busy), 1);
    b_fifo_count = 6'd0;
    for (int k = 0; k < 8; k++)
      do_burst("t2_b", 1'b1, 32'h0000_8000 + 32'(4 * k));
    wait_done("t2");

    // Memory back-pressure: request held stable for 5 cycles
    rd_req_ready = 1'b0;
    start_run(8'd1, 32'h0000_3000, 32'h0000_4000);
    wait_req("t3_a0", 32'h0000_3000, ok);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(rd_req_valid), 1);
      chk("t3_hold_addr", 64'(rd_req_addr), 64'h3000);
    end
    tick();
    rd_req_ready = 1'b1;
    resp_burst("t3_a0", 1'b0, 32'h0000_3000, 3);
`ifdef MM_FETCH_PERF_EN
    chk("t3_perf_req_wait", 64'(perf_req_wait), 5);
`endif
    for (int k = 1; k < 4; k++)
      do_burst("t3_a", 1'b0, 32'h0000_3000 + 32'(4 * k));
    for (int k = 0; k < 4; k++)
      do_burst("t3_b", 1'b1, 32'h0000_4000 + 32'(4 * k));
    wait_done("t3");

    // num_tiles = 0: done two cycles after start, no requests
    tick();
    snap();
    num_tiles = 8'd0;
    start     = 1'b1;
    @(negedge clk);
    chk("t4_busy_c0", 64'(busy), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t4_busy_c1", 64'(busy), 1);
    chk("t4_done_c1", 64'(done), 0);
    @(negedge clk);
    chk("t4_done_c2", 64'(done), 1);
    @(negedge clk);
    chk("t4_done_c3", 64'(done), 0);
    tick();
    chk("t4_no_req", 64'(valid_cnt - s_valid), 0);

    // Early rd_resp_last flags err; burst still runs to the 4th word and FSM continues
    start_run(8'd1, 32'h0000_5000, 32'h0000_6000);
    wait_req("t5_a0", 32'h0000_5000, ok);
    chk("t5_err_before", 64'(err), 0);
    resp_burst("t5_a0", 1'b0, 32'h0000_5000, 1);
    @(negedge clk);
    chk("t5_err_early_last", 64'(err), 1);
    wait_req("t5_a1", 32'h0000_5004, ok);

    // Reset while a response is in flight
    tick();
    rd_resp_valid = 1'b1;
    rd_resp_data  = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("t6_resp_wr", 64'(a_fifo_wr_en), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_a_wr", 64'(a_fifo_wr_en), 0);
    chk("t6_rst_wdata", fifo_wdata, 0);
    chk("t6_rst_err", 64'(err), 0);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_valid", 64'(rd_req_valid), 0);
    rd_resp_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Unsolicited response in IDLE: no write, err set
    tick();
    rd_resp_valid = 1'b1;
    rd_resp_data  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    chk("t7_idle_a_wr", 64'(a_fifo_wr_en), 0);
    chk("t7_idle_b_wr", 64'(b_fifo_wr_en), 0);
    chk("t7_idle_wdata", fifo_wdata, 0);
    tick();
    rd_resp_valid = 1'b0;
    @(negedge clk);
    chk("t7_idle_err", 64'(err), 1);

    // Fresh start after reset fetches from tile 0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_run(8'd1, 32'h0000_7000, 32'h0000_7800);
    do_burst("t8_a0", 1'b0, 32'h0000_7000);
    @(negedge clk);
    chk("t8_busy", 64'(busy), 1);
    chk("t8_err", 64'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
